// File: rtl/sample_unpacker_if.sv
// Handshake bundle for the sample unpacker: config strobe, packed-word input, unpacked output.
interface sample_unpacker_if;
   logic            cfg_stb_i;
   logic [3:0]      cfg_i;
   logic            in_stb_i;
   logic            in_rdy_o;
   logic [3:0][7:0] d_i;
   logic            stb_o;
   logic            rdy_i;
   logic [3:0][7:0] q_o;

   // Driver side: config source, sample-memory read port and downstream ready.
   modport master (
      output cfg_stb_i, cfg_i, in_stb_i, d_i, rdy_i,
      input  in_rdy_o, stb_o, q_o
   );

   // Unpacker side.
   modport slave (
      input  cfg_stb_i, cfg_i, in_stb_i, d_i, rdy_i,
      output in_rdy_o, stb_o, q_o
   );
endinterface

// File: rtl/sample_unpacker.sv
// Re-expands dense packed 32-bit words (enabled-lane bytes only) into full 4-lane samples.
// Disabled lanes read as zero. An 8-byte buffer absorbs words; one sample leaves per emit.
module sample_unpacker (
   input  logic             clk_i,
   input  logic             rst_in,
   sample_unpacker_if.slave bus
);
   logic [3:0]      cfg_q, cfg_d;
   logic [7:0][7:0] byte_buf_q, byte_buf_d, buf_shift;
   logic [3:0]      cnt_q, cnt_d, cnt_mid;
   logic            stb_q, stb_d;
   logic [3:0][7:0] q_q, q_d, q_sel;
   logic [2:0]      n;
   logic [2:0]      idx;
   logic            in_rdy, accept, loadable, emit;
   logic [6:0]      app_sh;
   logic [63:0]     word_ext, word_mask;

   // Number of enabled lanes, i.e. bytes consumed per sample.
   always_comb begin
      n = 3'(cfg_q[0]) + 3'(cfg_q[1]) + 3'(cfg_q[2]) + 3'(cfg_q[3]);
   end

   // Handshake qualifiers; in_rdy only sees registered state plus the flush strobe.
   always_comb begin
      in_rdy   = (cnt_q <= 4'd4) & ~bus.cfg_stb_i;
      accept   = bus.in_stb_i & in_rdy;
      loadable = ~stb_q | bus.rdy_i;
      emit     = loadable & (n != 3'd0) & (cnt_q >= {1'b0, n});
   end

   // Route the oldest buffered bytes to enabled lanes in ascending lane order.
   always_comb begin
      q_sel = '0;
      idx   = '0;
      for (int k = 0; k < 4; k++) begin
         if (cfg_q[k]) begin
            q_sel[k] = byte_buf_q[idx];
            idx      = idx + 3'd1;
         end
      end
   end

   // Next state: flush beats emit/accept; accept appends after the same-cycle emit shift.
   always_comb begin
      cfg_d      = cfg_q;
      byte_buf_d = byte_buf_q;
      cnt_d      = cnt_q;
      stb_d      = stb_q;
      q_d        = q_q;
      buf_shift  = byte_buf_q;
      cnt_mid    = cnt_q;
      app_sh     = '0;
      word_ext   = '0;
      word_mask  = '0;
      if (bus.cfg_stb_i) begin
         cfg_d      = bus.cfg_i;
         byte_buf_d = '0;
         cnt_d      = '0;
         stb_d      = 1'b0;
      end else begin
         if (loadable) begin
            stb_d = emit;
         end
         if (emit) begin
            q_d       = q_sel;
            buf_shift = byte_buf_q >> {n, 3'b000};
            cnt_mid   = cnt_q - {1'b0, n};
         end
         app_sh     = {cnt_mid, 3'b000};
         word_ext   = 64'(bus.d_i) << app_sh;
         word_mask  = 64'hFFFF_FFFF << app_sh;
         byte_buf_d = buf_shift;
         cnt_d      = cnt_mid;
         // With no lanes enabled, accepted words are simply dropped.
         if (accept && (n != 3'd0)) begin
            byte_buf_d = (buf_shift & ~word_mask) | word_ext;
            cnt_d      = cnt_mid + 4'd4;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         cfg_q      <= '0;
         byte_buf_q <= '0;
         cnt_q      <= '0;
         stb_q      <= 1'b0;
         q_q        <= '0;
      end else begin
         cfg_q      <= cfg_d;
         byte_buf_q <= byte_buf_d;
         cnt_q      <= cnt_d;
         stb_q      <= stb_d;
         q_q        <= q_d;
      end
   end

   assign bus.in_rdy_o = in_rdy;
   assign bus.stb_o    = stb_q;
   assign bus.q_o      = q_q;

   // Buffer occupancy must stay within 0..8; a wrap from underflow also lands above 8.
   cnt_bound_a : assert property (@(posedge clk_i) disable iff (!rst_in) cnt_q <= 4'd8);
endmodule

// File: tb/tb_sample_unpacker.sv
// Bench for sample_unpacker: directed scenarios plus random traffic against a byte-queue model.
module tb_sample_unpacker;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   sample_unpacker_if bus ();
   sample_unpacker dut (.clk_i(clk), .rst_in(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model: enabled mask, FIFO of pending bytes, output register.
   logic [3:0]   m_cfg;
   byte unsigned m_q[$];
   logic         m_stb;
   logic [31:0]  m_out;

   logic [31:0]  obs[$];
   logic [31:0]  exp_q[$];
   bit           acc_flag;
   int           max_stall;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      m_cfg = '0;
      m_q.delete();
      m_stb = 1'b0;
      m_out = '0;
   endtask

   // One clock: check ready at negedge, advance the model at posedge, check outputs after.
   task automatic step();
      int n;
      bit exp_rdy;
      bit acc;
      @(negedge clk);
      exp_rdy = !bus.cfg_stb_i && (m_q.size() <= 4);
      chk("in_rdy_o", 32'(bus.in_rdy_o), 32'(exp_rdy));
      if (bus.stb_o && bus.rdy_i) obs.push_back(bus.q_o);
      acc      = bus.in_stb_i && exp_rdy;
      acc_flag = acc;
      @(posedge clk);
      if (bus.cfg_stb_i) begin
         m_cfg = bus.cfg_i;
         m_q.delete();
         m_stb = 1'b0;
      end else begin
         n = $countones(m_cfg);
         if (!m_stb || bus.rdy_i) begin
            if (n != 0 && m_q.size() >= n) begin
               for (int k = 0; k < 4; k++) begin
                  if (m_cfg[k]) m_out[8*k +: 8] = m_q.pop_front();
                  else          m_out[8*k +: 8] = 8'h00;
               end
               m_stb = 1'b1;
            end else begin
               m_stb = 1'b0;
            end
         end
         if (acc && n != 0) begin
            for (int j = 0; j < 4; j++) m_q.push_back(bus.d_i[j]);
         end
      end
      #1;
      chk("stb_o", 32'(bus.stb_o), 32'(m_stb));
      chk("q_o", bus.q_o, m_out);
   endtask

   task automatic idle(input int cycles);
      bus.in_stb_i  = 1'b0;
      bus.cfg_stb_i = 1'b0;
      repeat (cycles) step();
   endtask

   task automatic set_cfg(input logic [3:0] c);
      bus.cfg_stb_i = 1'b1;
      bus.cfg_i     = c;
      bus.in_stb_i  = 1'b0;
      step();
      bus.cfg_stb_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      int waited = 0;
      bus.in_stb_i = 1'b1;
      bus.d_i      = w;
      do begin
         step();
         if (!acc_flag) waited++;
      end while (!acc_flag && waited < 20);
      if (!acc_flag) chk("accept_timeout", 32'(acc_flag), 32'd1);
      if (waited > max_stall) max_stall = waited;
      bus.in_stb_i = 1'b0;
   endtask

   task automatic check_obs(input string tag);
      chk({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) chk(tag, (i < obs.size()) ? obs[i] : 32'hxxxx_xxxx, exp_q[i]);
      obs.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cfg_stb_i = 1'b0;
      bus.cfg_i     = '0;
      bus.in_stb_i  = 1'b0;
      bus.d_i       = '0;
      bus.rdy_i     = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #2;
      chk("reset_stb", 32'(bus.stb_o), 32'd0);
      chk("reset_q", bus.q_o, 32'd0);
      chk("reset_rdy", 32'(bus.in_rdy_o), 32'd1);
      @(negedge clk) rst_n = 1'b1;

      // Full mask: one word, one sample.
      set_cfg(4'b1111);
      send(32'h4433_2211);
      idle(3);
      exp_q = '{32'h4433_2211};
      check_obs("t1_all_lanes");

      // Sparse mask: two samples from one word.
      set_cfg(4'b0101);
      send(32'hDDCC_BBAA);
      idle(4);
      exp_q = '{32'h00BB_00AA, 32'h00DD_00CC};
      check_obs("t2_sparse");
      chk("t2_idle_stb", 32'(bus.stb_o), 32'd0);

      // Three lanes, words straddling samples, streamed back-to-back.
      set_cfg(4'b0111);
      max_stall = 0;
      send(32'h0403_0201);
      send(32'h0807_0605);
      send(32'h0C0B_0A09);
      idle(6);
      exp_q = '{32'h0003_0201, 32'h0006_0504, 32'h0009_0807, 32'h000C_0B0A};
      check_obs("t3_stream");
      chk("t3_max_stall", 32'(max_stall <= 1), 32'd1);

      // Single lane with downstream stall: output must hold.
      set_cfg(4'b0001);
      bus.rdy_i = 1'b0;
      send(32'h4433_2211);
      repeat (5) begin
         step();
         chk("t4_hold_q", bus.q_o, 32'h0000_0011);
         chk("t4_hold_stb", 32'(bus.stb_o), 32'd1);
      end
      bus.rdy_i = 1'b1;
      idle(6);
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
      check_obs("t4_drain");

      // Flush drops the leftover byte and ignores the same-cycle word.
      set_cfg(4'b0111);
      send(32'h0403_0201);
      idle(2);
      exp_q = '{32'h0003_0201};
      check_obs("t5_pre");
      bus.cfg_stb_i = 1'b1;
      bus.cfg_i     = 4'b1111;
      bus.in_stb_i  = 1'b1;
      bus.d_i       = 32'hDEAD_BEEF;
      #1 chk("t5_flush_rdy", 32'(bus.in_rdy_o), 32'd0);
      step();
      chk("t5_flush_stb", 32'(bus.stb_o), 32'd0);
      bus.cfg_stb_i = 1'b0;
      send(32'hA1B2_C3D4);
      idle(3);
      exp_q = '{32'hA1B2_C3D4};
      check_obs("t5_post");

      // Asynchronous reset mid-stream with a pending sample.
      set_cfg(4'b1111);
      bus.rdy_i = 1'b0;
      send(32'h5566_7788);
      idle(2);
      chk("t6_pending", 32'(bus.stb_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_stb", 32'(bus.stb_o), 32'd0);
      chk("t6_rst_q", bus.q_o, 32'd0);
      chk("t6_rst_rdy", 32'(bus.in_rdy_o), 32'd1);
      model_reset();
      obs.delete();
      @(negedge clk) rst_n = 1'b1;
      bus.rdy_i = 1'b1;
      send(32'h1234_5678);
      send(32'h9ABC_DEF0);
      idle(4);
      exp_q.delete();
      check_obs("t6_discard");

      // Random traffic with occasional reconfiguration.
      set_cfg(4'($urandom));
      for (int c = 0; c < 600; c++) begin
         bus.cfg_stb_i = ($urandom_range(0, 39) == 0);
         bus.cfg_i     = 4'($urandom);
         bus.in_stb_i  = 1'($urandom);
         bus.d_i       = $urandom;
         bus.rdy_i     = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sample_unpacker.md
Name: sample_unpacker

Overview:
- Read-side counterpart of the capture packer.
- Takes dense 32-bit memory words, which hold only the bytes of enabled channels, and re-expands them into full 4-lane samples. Disabled lanes are zero-filled.
- Sits between the sample-memory read port and the transmit/readout path.
- Packed format: byte 0 of a word is the oldest. Within one sample, enabled lanes appear in ascending lane order. Samples may straddle word boundaries.

Parameters:
- None. Lane count is 4 and lane width is 8 bits, both fixed.

Ports:
- clk_i       in   1       system clock
- rst_in      in   1       reset; asynchronous, active-low
- cfg_stb_i   in   1       cfg_i valid this cycle; also flushes internal state
- cfg_i       in   4       enabled-lane mask (bit k = lane k)
- in_stb_i    in   1       packed word valid
- in_rdy_o    out  1       unpacker accepts word this cycle
- d_i         in   4x8     packed word, d_i[0] oldest byte
- stb_o       out  1       unpacked sample valid
- rdy_i       in   1       downstream accepts sample
- q_o         out  4x8     unpacked sample, q_o[k] = lane k

Behaviour:
- Reset (rst_in low, async): byte buffer cleared, cnt=0, cfg=0, stb_o=0, q_o=0. in_rdy_o follows from cnt=0 and cfg=0, i.e. it is 1.
- State:
  - cfg register (4b).
  - n = popcount(cfg), range 0..4.
  - 8-byte buffer buf[0..7], with buf[0] oldest.
  - cnt = valid bytes in the buffer, range 0..8, held in 4 bits.
  - Output register (stb_o, q_o).
- Input handshake:
  - in_rdy_o = (cnt <= 4). It is derived from registered state only, with no combinational path from rdy_i.
  - Word transfer happens when in_stb_i & in_rdy_o.
- Output handshake:
  - stb_o is held with q_o stable until rdy_i. Transfer happens when stb_o & rdy_i.
  - Output register loadable when (~stb_o | rdy_i).
- Emit condition: loadable & n!=0 & cnt>=n. On emit, in the same clock:
  - The i-th set bit of cfg (ascending) takes buf[i]. Clear bits of cfg give 8'h00.
  - The buffer shifts down by n and cnt -= n.
  - stb_o <= 1.
- Loadable with no emit: stb_o <= 0, and q_o keeps its last value.
- Word accept:
  - The 4 bytes are appended at buf[cnt'..cnt'+3], where cnt' is cnt after any same-cycle emit.
  - cnt' + 4 <= 8 always holds.
- Simultaneous emit and accept in one cycle is required. Sustained throughput is one sample per cycle when n=1, limited by input rate otherwise.
- Latency: a word accepted in cycle t can appear in q_o at the earliest in cycle t+1. No bypass from d_i to q_o.
- Data bytes are never reordered, duplicated or dropped while cfg is unchanged.
- cfg=0 (n=0):
  - No samples are emitted.
  - Accepted words are discarded and cnt is held at 0, so in_rdy_o=1.
- cfg_stb_i:
  - cfg <= cfg_i, cnt <= 0, stb_o <= 0.
  - Any pending sample or partial bytes are dropped.
  - in_stb_i in that cycle is ignored: no transfer, and in_rdy_o is forced to 0 in that cycle.
  - This takes priority over emit and accept.
- Residual bytes (cnt < n) are held until more words arrive or a flush occurs. There is no timeout.
- Reset asserted mid-operation aborts immediately to reset values. No handshake completes in that cycle.
- cnt never exceeds 8 and never underflows. Assert this in simulation.

Test Plan:
- cfg_i=4'b1111 strobed, then word 0x44332211 with rdy_i=1 -> next cycle stb_o=1, q_o=0x44332211; one word gives one sample.
- cfg_i=4'b0101, word 0xDDCCBBAA -> two consecutive samples q_o=0x00BB00AA then 0x00DD00CC; then stb_o=0, cnt=0.
- cfg_i=4'b0111, words 0x04030201, 0x08070605, 0x0C0B0A09 streamed back-to-back -> samples 0x00030201, 0x00060504, 0x00090807, 0x000C0B0A in order; in_rdy_o never stalls the input for more than 1 cycle.
- cfg_i=4'b0001, word 0x44332211, rdy_i low for 5 cycles then high -> q_o holds 0x00000011 with stb_o=1 during the stall; then 0x11, 0x22, 0x33, 0x44 appear in lane 0 on 4 consecutive cycles; in_rdy_o=0 while cnt>4.
- cfg_i=4'b0111, one word (cnt=1 left after the sample), then cfg_stb_i with 4'b1111 -> stb_o=0, leftover byte discarded; next word 0xA1B2C3D4 -> q_o=0xA1B2C3D4.
- rst_in pulsed low mid-stream with stb_o=1 -> stb_o=0, q_o=0, in_rdy_o=1 asynchronously; after release cfg=0 and words are discarded with no stb_o.
